spi_bus_ctrl: RTL and testbench

- Bus-side stage between the physical SPI lines and the MITM decision logic.
- Observes SS/SCLK from the real master and captures MOSI/MISO bits in chunks whose size is commanded by the MITM logic.
- Forwards each line unchanged or substitutes bits from a fake-data buffer.
- Reports status to the MITM logic through comm_active/bus_ready and returns captured chunks on real_mosi_data/real_miso_data.

---
 rtl/spi_bus_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_spi_bus_ctrl.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_ctrl.sv
// spi_bus_ctrl: bus-side tap between a real SPI master and slave.
// Captures MOSI/MISO chunks on command and can substitute fake bits.
module spi_bus_ctrl #(
    parameter int BUF_SIZE         = 9,
    parameter int CHUNK_SIZE_WIDTH = $clog2(BUF_SIZE + 1),
    parameter int SYNC_STAGES      = 2
) (
    input  logic                        sys_clk,
    input  logic                        rst,
    input  logic                        sclk_in,
    input  logic                        ss_in,
    input  logic                        mosi_in,
    input  logic                        miso_in,
    output logic                        mosi_out,
    output logic                        miso_out,
    output logic                        comm_active,
    output logic                        bus_ready,
    output logic [BUF_SIZE-1:0]         real_mosi_data,
    output logic [BUF_SIZE-1:0]         real_miso_data,
    input  logic                        cmd_next_chunk,
    input  logic                        cmd_finish,
    input  logic [CHUNK_SIZE_WIDTH-1:0] next_chunk_size,
    input  logic                        fake_mosi_select,
    input  logic                        fake_miso_select,
    input  logic [BUF_SIZE-1:0]         fake_mosi_data,
    input  logic [BUF_SIZE-1:0]         fake_miso_data
);

    localparam int CW = CHUNK_SIZE_WIDTH;
    localparam logic [CW-1:0] SIZE_MAX = CW'(BUF_SIZE);
    localparam logic [CW-1:0] ONE      = CW'(1);

    typedef enum logic [1:0] {IDLE, ACTIVE, XFER, FINISH} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] miso_sync_q, miso_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   ss_prev_q, ss_prev_d;

    logic [CW-1:0]       size_q, size_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       ptr_q, ptr_d;
    logic                sub_mosi_q, sub_mosi_d;
    logic                sub_miso_q, sub_miso_d;
    logic                hold_q, hold_d;
    logic                skip_q, skip_d;
    logic [BUF_SIZE-1:0] fake_mosi_q, fake_mosi_d;
    logic [BUF_SIZE-1:0] fake_miso_q, fake_miso_d;
    logic [BUF_SIZE-1:0] shift_mosi_q, shift_mosi_d;
    logic [BUF_SIZE-1:0] shift_miso_q, shift_miso_d;
    logic [BUF_SIZE-1:0] real_mosi_q, real_mosi_d;
    logic [BUF_SIZE-1:0] real_miso_q, real_miso_d;

    logic          sclk_s, ss_s, mosi_s, miso_s;
    logic          sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic          start_chunk, in_xfer, chunk_done, clear_sel;
    logic [CW-1:0] n_clamp;

    // Synchroniser chains and edge-detect inputs; data shares clock depth
    always_comb begin
        sclk_sync_d = (sclk_sync_q << 1) | SYNC_STAGES'(sclk_in);
        ss_sync_d   = (ss_sync_q << 1) | SYNC_STAGES'(ss_in);
        mosi_sync_d = (mosi_sync_q << 1) | SYNC_STAGES'(mosi_in);
        miso_sync_d = (miso_sync_q << 1) | SYNC_STAGES'(miso_in);
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        ss_s        = ss_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        miso_s      = miso_sync_q[SYNC_STAGES-1];
        sclk_prev_d = sclk_s;
        ss_prev_d   = ss_s;
        sclk_rise   = sclk_s & ~sclk_prev_q;
        sclk_fall   = ~sclk_s & sclk_prev_q;
        ss_rise     = ss_s & ~ss_prev_q;
        ss_fall     = ~ss_s & ss_prev_q;
    end

    // Synchroniser registers; SS idles high so its chain resets to ones
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            miso_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            miso_sync_q <= miso_sync_d;
            sclk_prev_q <= sclk_prev_d;
            ss_prev_q   <= ss_prev_d;
        end
    end

    // Command qualification shared by the FSM and the datapath
    always_comb begin
        n_clamp = (next_chunk_size > SIZE_MAX) ? SIZE_MAX : next_chunk_size;
        start_chunk = (state_q == ACTIVE) && !ss_rise && !cmd_finish &&
                      cmd_next_chunk && (next_chunk_size != '0);
        in_xfer    = (state_q == XFER) && !ss_rise;
        chunk_done = in_xfer && sclk_rise && ((cnt_q + ONE) == size_q);
        clear_sel  = ss_rise || (state_q == IDLE) || (state_q == FINISH) ||
                     ((state_q == ACTIVE) && cmd_finish);
    end

    // FSM state register
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // FSM next-state logic; SS release always wins
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ss_fall) state_d = ACTIVE;
            ACTIVE: begin
                if (ss_rise)          state_d = IDLE;
                else if (cmd_finish)  state_d = FINISH;
                else if (start_chunk) state_d = XFER;
            end
            XFER: begin
                if (ss_rise)         state_d = IDLE;
                else if (chunk_done) state_d = ACTIVE;
            end
            FINISH:  if (ss_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM status outputs
    always_comb begin
        comm_active = 1'b1;
        bus_ready   = 1'b0;
        unique case (state_q)
            IDLE: begin
                comm_active = 1'b0;
                bus_ready   = 1'b1;
            end
            ACTIVE:  bus_ready = 1'b1;
            XFER:    bus_ready = 1'b0;
            FINISH:  bus_ready = 1'b0;
            default: bus_ready = 1'b0;
        endcase
    end

    // Chunk datapath: latch, capture, fake pointer and substitution hold
    always_comb begin
        size_d       = size_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        sub_mosi_d   = sub_mosi_q;
        sub_miso_d   = sub_miso_q;
        hold_d       = hold_q;
        skip_d       = skip_q;
        fake_mosi_d  = fake_mosi_q;
        fake_miso_d  = fake_miso_q;
        shift_mosi_d = shift_mosi_q;
        shift_miso_d = shift_miso_q;
        real_mosi_d  = real_mosi_q;
        real_miso_d  = real_miso_q;
        if (start_chunk) begin
            size_d       = n_clamp;
            cnt_d        = '0;
            ptr_d        = n_clamp - ONE;
            sub_mosi_d   = fake_mosi_select;
            sub_miso_d   = fake_miso_select;
            fake_mosi_d  = fake_mosi_data;
            fake_miso_d  = fake_miso_data;
            shift_mosi_d = '0;
            shift_miso_d = '0;
            hold_d       = 1'b0;
            // a still-pending falling edge belongs to the previous chunk
            skip_d       = hold_q && !sclk_fall;
        end else if (in_xfer) begin
            if (sclk_rise) begin
                shift_mosi_d = (shift_mosi_q << 1) | BUF_SIZE'(mosi_s);
                shift_miso_d = (shift_miso_q << 1) | BUF_SIZE'(miso_s);
                cnt_d        = cnt_q + ONE;
                if (chunk_done) begin
                    real_mosi_d = shift_mosi_d;
                    real_miso_d = shift_miso_d;
                    hold_d      = 1'b1;
                end
            end
            if (sclk_fall) begin
                if (skip_q)            skip_d = 1'b0;
                else if (ptr_q != '0)  ptr_d  = ptr_q - ONE;
            end
        end else if (hold_q && sclk_fall) begin
            sub_mosi_d = 1'b0;
            sub_miso_d = 1'b0;
            hold_d     = 1'b0;
        end
        if (clear_sel) begin
            sub_mosi_d = 1'b0;
            sub_miso_d = 1'b0;
            hold_d     = 1'b0;
            skip_d     = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            size_q       <= '0;
            cnt_q        <= '0;
            ptr_q        <= '0;
            sub_mosi_q   <= 1'b0;
            sub_miso_q   <= 1'b0;
            hold_q       <= 1'b0;
            skip_q       <= 1'b0;
            fake_mosi_q  <= '0;
            fake_miso_q  <= '0;
            shift_mosi_q <= '0;
            shift_miso_q <= '0;
            real_mosi_q  <= '0;
            real_miso_q  <= '0;
        end else begin
            size_q       <= size_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            sub_mosi_q   <= sub_mosi_d;
            sub_miso_q   <= sub_miso_d;
            hold_q       <= hold_d;
            skip_q       <= skip_d;
            fake_mosi_q  <= fake_mosi_d;
            fake_miso_q  <= fake_miso_d;
            shift_mosi_q <= shift_mosi_d;
            shift_miso_q <= shift_miso_d;
            real_mosi_q  <= real_mosi_d;
            real_miso_q  <= real_miso_d;
        end
    end

    assign mosi_out       = sub_mosi_q ? fake_mosi_q[ptr_q] : mosi_in;
    assign miso_out       = sub_miso_q ? fake_miso_q[ptr_q] : miso_in;
    assign real_mosi_data = real_mosi_q;
    assign real_miso_data = real_miso_q;

endmodule

// File: tb/tb_spi_bus_ctrl.sv
// tb_spi_bus_ctrl: drives an SPI master/slave pair through the tap
// and checks capture and substitution against a bit-level model.
module tb_spi_bus_ctrl;

    localparam int BUF = 9;
    localparam int SYNC = 2;
    localparam int H = 6;

    logic           sys_clk, rst;
    logic           sclk_in, ss_in, mosi_in, miso_in;
    logic           mosi_out, miso_out, comm_active, bus_ready;
    logic [BUF-1:0] real_mosi_data, real_miso_data;
    logic           cmd_next_chunk, cmd_finish;
    logic [3:0]     next_chunk_size;
    logic           fake_mosi_select, fake_miso_select;
    logic [BUF-1:0] fake_mosi_data, fake_miso_data;

    int n_run, n_fail;
    logic [BUF-1:0] exp_mo, exp_mi;

    spi_bus_ctrl dut (
        .sys_clk(sys_clk), .rst(rst),
        .sclk_in(sclk_in), .ss_in(ss_in),
        .mosi_in(mosi_in), .miso_in(miso_in),
        .mosi_out(mosi_out), .miso_out(miso_out),
        .comm_active(comm_active), .bus_ready(bus_ready),
        .real_mosi_data(real_mosi_data),
        .real_miso_data(real_miso_data),
        .cmd_next_chunk(cmd_next_chunk), .cmd_finish(cmd_finish),
        .next_chunk_size(next_chunk_size),
        .fake_mosi_select(fake_mosi_select),
        .fake_miso_select(fake_miso_select),
        .fake_mosi_data(fake_mosi_data),
        .fake_miso_data(fake_miso_data)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int k);
        repeat (k) @(negedge sys_clk);
    endtask

    task automatic ss_begin();
        int k;
        k = 0;
        sclk_in = 1'b0;
        ss_in = 1'b0;
        while (comm_active !== 1'b1 && k < 10) begin
            tick(1);
            k++;
        end
        n_run++;
        if (comm_active !== 1'b1 || k > SYNC + 2) begin
            n_fail++;
            $display("FAIL ss_begin: comm_active=%b after %0d cycles, want 1 within %0d",
                     comm_active, k, SYNC + 2);
        end
        n_run++;
        if (bus_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ss_begin_ready: got %b want 1", bus_ready);
        end
    endtask

    task automatic ss_end();
        int k;
        k = 0;
        sclk_in = 1'b0;
        ss_in = 1'b1;
        while (comm_active !== 1'b0 && k < 10) begin
            tick(1);
            k++;
        end
        n_run++;
        if (comm_active !== 1'b0) begin
            n_fail++;
            $display("FAIL ss_end: comm_active got %b want 0", comm_active);
        end
        n_run++;
        if (bus_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ss_end_ready: got %b want 1", bus_ready);
        end
        tick(2);
    endtask

    // One chunk: master sends the low n bits of m_bits MSB first.
    task automatic do_chunk(input int req, input bit s_mo, input bit s_mi,
                            input logic [BUF-1:0] f_mo, input logic [BUF-1:0] f_mi,
                            input logic [BUF-1:0] m_bits, input logic [BUF-1:0] s_bits,
                            input int abort_at, input bit mid_cmd);
        int n;
        logic e_mo, e_mi;
        n = (req > BUF) ? BUF : req;
        next_chunk_size = 4'(req);
        fake_mosi_select = s_mo;
        fake_miso_select = s_mi;
        fake_mosi_data = f_mo;
        fake_miso_data = f_mi;
        cmd_next_chunk = 1'b1;
        tick(1);
        cmd_next_chunk = 1'b0;
        fake_mosi_select = ~s_mo;
        fake_miso_select = ~s_mi;
        fake_mosi_data = 9'($urandom);
        fake_miso_data = 9'($urandom);
        n_run++;
        if (bus_ready !== (n == 0)) begin
            n_fail++;
            $display("FAIL cmd_ready n=%0d: got %b want %b", n, bus_ready, n == 0);
        end
        if (n == 0) return;
        for (int i = 0; i < n; i++) begin
            sclk_in = 1'b0;
            mosi_in = m_bits[n-1-i];
            miso_in = s_bits[n-1-i];
            if (mid_cmd && i == 1) begin
                cmd_finish = 1'b1;
                cmd_next_chunk = 1'b1;
                next_chunk_size = 4'd1;
                tick(1);
                cmd_finish = 1'b0;
                cmd_next_chunk = 1'b0;
                tick(H - 1);
            end else begin
                tick(H);
            end
            e_mo = s_mo ? f_mo[n-1-i] : mosi_in;
            e_mi = s_mi ? f_mi[n-1-i] : miso_in;
            n_run++;
            if (mosi_out !== e_mo || miso_out !== e_mi) begin
                n_fail++;
                $display("FAIL bit%0d_out: mosi/miso got %b%b want %b%b",
                         i, mosi_out, miso_out, e_mo, e_mi);
            end
            n_run++;
            if (bus_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bit%0d_busy: bus_ready got %b want 0", i, bus_ready);
            end
            if (i == abort_at) begin
                ss_in = 1'b1;
                tick(SYNC + 3);
                n_run++;
                if (comm_active !== 1'b0 || bus_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL abort_status: active/ready got %b%b want 01",
                             comm_active, bus_ready);
                end
                n_run++;
                if (real_mosi_data !== exp_mo || real_miso_data !== exp_mi) begin
                    n_fail++;
                    $display("FAIL abort_data: got %h/%h want %h/%h",
                             real_mosi_data, real_miso_data, exp_mo, exp_mi);
                end
                n_run++;
                if (mosi_out !== mosi_in || miso_out !== miso_in) begin
                    n_fail++;
                    $display("FAIL abort_pass: got %b%b want %b%b",
                             mosi_out, miso_out, mosi_in, miso_in);
                end
                return;
            end
            sclk_in = 1'b1;
            tick(H);
            if (i == n - 1) begin
                exp_mo = 9'(int'(m_bits) % (1 << n));
                exp_mi = 9'(int'(s_bits) % (1 << n));
                n_run++;
                if (bus_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL done_ready: got %b want 1", bus_ready);
                end
                n_run++;
                if (real_mosi_data !== exp_mo || real_miso_data !== exp_mi) begin
                    n_fail++;
                    $display("FAIL done_data n=%0d: got %h/%h want %h/%h",
                             n, real_mosi_data, real_miso_data, exp_mo, exp_mi);
                end
                n_run++;
                if (mosi_out !== e_mo || miso_out !== e_mi) begin
                    n_fail++;
                    $display("FAIL last_hold: got %b%b want %b%b",
                             mosi_out, miso_out, e_mo, e_mi);
                end
            end
        end
        sclk_in = 1'b0;
        mosi_in = ~mosi_in;
        miso_in = ~miso_in;
        tick(H);
        n_run++;
        if (mosi_out !== mosi_in || miso_out !== miso_in) begin
            n_fail++;
            $display("FAIL post_pass: got %b%b want %b%b",
                     mosi_out, miso_out, mosi_in, miso_in);
        end
        n_run++;
        if (bus_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_ready: got %b want 1", bus_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mosi_in = 1'b1;
        miso_in = 1'b0;
        tick(3);
        n_run++;
        if (comm_active !== 1'b0 || bus_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_status: active/ready got %b%b want 01",
                     comm_active, bus_ready);
        end
        n_run++;
        if (real_mosi_data !== 9'h000 || real_miso_data !== 9'h000) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h want 000/000",
                     real_mosi_data, real_miso_data);
        end
        n_run++;
        if (mosi_out !== 1'b1 || miso_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pass: got %b%b want 10", mosi_out, miso_out);
        end
        rst = 1'b1;
        tick(3);
        exp_mo = '0;
        exp_mi = '0;
    endtask

    task automatic test_forward();
        ss_begin();
        n_run++;
        if (real_mosi_data !== 9'h000) begin
            n_fail++;
            $display("FAIL start_data: got %h want 000", real_mosi_data);
        end
        do_chunk(3, 0, 0, 9'h1FF, 9'h1FF, 9'h006, 9'h005, -1, 0);
        do_chunk(9, 0, 0, 9'h1FF, 9'h1FF, 9'h14A, 9'h000, -1, 0);
        ss_end();
    endtask

    task automatic test_substitute();
        ss_begin();
        do_chunk(8, 1, 0, 9'h055, 9'h000, 9'h0AA, 9'h133, -1, 0);
        do_chunk(5, 1, 1, 9'h00C, 9'h013, 9'h1F0, 9'h0E4, -1, 0);
        ss_end();
    endtask

    task automatic test_abort();
        ss_begin();
        do_chunk(6, 0, 0, 9'h000, 9'h000, 9'h02D, 9'h011, -1, 0);
        do_chunk(9, 1, 1, 9'h0F0, 9'h10F, 9'h10F, 9'h0F0, 4, 0);
        ss_end();
        ss_begin();
        do_chunk(4, 0, 1, 9'h000, 9'h00A, 9'h009, 9'h006, -1, 0);
        ss_end();
    endtask

    task automatic test_finish_wins();
        ss_begin();
        next_chunk_size = 4'd5;
        fake_mosi_select = 1'b1;
        fake_miso_select = 1'b1;
        fake_mosi_data = 9'h1FF;
        fake_miso_data = 9'h1FF;
        cmd_next_chunk = 1'b1;
        cmd_finish = 1'b1;
        tick(1);
        cmd_next_chunk = 1'b0;
        cmd_finish = 1'b0;
        n_run++;
        if (bus_ready !== 1'b0 || comm_active !== 1'b1) begin
            n_fail++;
            $display("FAIL finish_status: active/ready got %b%b want 10",
                     comm_active, bus_ready);
        end
        for (int i = 0; i < 5; i++) begin
            sclk_in = 1'b0;
            mosi_in = 1'b0;
            miso_in = 1'b0;
            tick(H);
            n_run++;
            if (mosi_out !== 1'b0 || miso_out !== 1'b0) begin
                n_fail++;
                $display("FAIL finish_pass%0d: got %b%b want 00", i, mosi_out, miso_out);
            end
            sclk_in = 1'b1;
            tick(H);
        end
        sclk_in = 1'b0;
        tick(H);
        n_run++;
        if (real_mosi_data !== exp_mo || bus_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL finish_nocap: data/ready got %h/%b want %h/0",
                     real_mosi_data, bus_ready, exp_mo);
        end
        ss_end();
    endtask

    task automatic test_ignored();
        next_chunk_size = 4'd3;
        cmd_next_chunk = 1'b1;
        tick(1);
        cmd_next_chunk = 1'b0;
        tick(1);
        n_run++;
        if (bus_ready !== 1'b1 || comm_active !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_cmd: active/ready got %b%b want 01",
                     comm_active, bus_ready);
        end
        ss_begin();
        for (int i = 0; i < 3; i++) begin
            mosi_in = 1'($urandom);
            miso_in = 1'($urandom);
            sclk_in = 1'b1;
            tick(H);
            sclk_in = 1'b0;
            tick(H);
        end
        n_run++;
        if (real_mosi_data !== exp_mo || real_miso_data !== exp_mi || bus_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL active_edges: got %h/%h/%b want %h/%h/1",
                     real_mosi_data, real_miso_data, bus_ready, exp_mo, exp_mi);
        end
        do_chunk(4, 0, 0, 9'h000, 9'h000, 9'h00B, 9'h004, -1, 1);
        ss_end();
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            int chunks;
            ss_begin();
            chunks = $urandom_range(1, 3);
            for (int c = 0; c < chunks; c++) begin
                do_chunk($urandom_range(0, 15), 1'($urandom), 1'($urandom),
                         9'($urandom), 9'($urandom), 9'($urandom), 9'($urandom),
                         -1, ($urandom_range(0, 3) == 0));
            end
            ss_end();
        end
    endtask

    task automatic test_reset_midxfer();
        ss_begin();
        mosi_in = 1'b0;
        miso_in = 1'b0;
        next_chunk_size = 4'd9;
        fake_mosi_select = 1'b1;
        fake_miso_select = 1'b1;
        fake_mosi_data = 9'h1FF;
        fake_miso_data = 9'h1FF;
        cmd_next_chunk = 1'b1;
        tick(1);
        cmd_next_chunk = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sclk_in = 1'b1;
            tick(H);
            sclk_in = 1'b0;
            tick(H);
        end
        n_run++;
        if (mosi_out !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_rst_sub: got %b want 1", mosi_out);
        end
        rst = 1'b0;
        #1;
        n_run++;
        if (mosi_out !== 1'b0 || miso_out !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_pass: got %b%b want 00", mosi_out, miso_out);
        end
        n_run++;
        if (comm_active !== 1'b0 || bus_ready !== 1'b1 || real_mosi_data !== 9'h000) begin
            n_fail++;
            $display("FAIL rst_status: got %b%b/%h want 01/000",
                     comm_active, bus_ready, real_mosi_data);
        end
        ss_in = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(3);
        exp_mo = '0;
        exp_mi = '0;
        ss_begin();
        do_chunk(7, 0, 1, 9'h000, 9'h055, 9'h04C, 9'h07F, -1, 0);
        ss_end();
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;
        rst = 1'b0;
        sclk_in = 1'b0;
        ss_in = 1'b1;
        mosi_in = 1'b0;
        miso_in = 1'b0;
        cmd_next_chunk = 1'b0;
        cmd_finish = 1'b0;
        next_chunk_size = '0;
        fake_mosi_select = 1'b0;
        fake_miso_select = 1'b0;
        fake_mosi_data = '0;
        fake_miso_data = '0;
        exp_mo = '0;
        exp_mi = '0;
        test_reset();
        test_forward();
        test_substitute();
        test_abort();
        test_finish_wins();
        test_ignored();
        test_random();
        test_reset_midxfer();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
